// File: rtl/sample_readout_if.sv
// Byte stream from the sample readout engine to the host-link transmitter:
// tx_data is held stable while tx_valid is high until tx_ready accepts it.
interface sample_readout_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/sample_readout.sv
// Sample RAM readout engine: walks the circular channel RAMs from the pre-trigger
// address and streams bytes over a valid/ready link. Define SAMPLE_READOUT_HEADER_EN
// to prefix each channel with the two-byte header (A5, channel index).
module sample_readout #(
  parameter int ram_width = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 data_ready,
  input  logic [3:0]           chan_mask,
  input  logic [ram_width-1:0] wraddress_triggerpoint,
  input  logic [ram_width-1:0] triggerpoint,
  input  logic [ram_width-1:0] nsmp,
  output logic                 rden,
  output logic [ram_width-1:0] rdaddress,
  input  logic [7:0]           q1,
  input  logic [7:0]           q2,
  input  logic [7:0]           q3,
  input  logic [7:0]           q4,
  sample_readout_if.master     tx,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 err_notready
);

`ifdef SAMPLE_READOUT_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  localparam logic [7:0] HDR_SYNC = 8'hA5;
  localparam logic [ram_width-1:0] ADDR_ONE = ram_width'(1);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    RDADDR,
    RDWAIT,
    SEND,
    NEXTCH
  } state_t;

  state_t               state_r, state_d;
  logic                 rden_r, rden_d;
  logic [ram_width-1:0] rdaddress_r, rdaddress_d;
  logic [7:0]           tx_data_r, tx_data_d;
  logic                 tx_valid_r, tx_valid_d;
  logic                 busy_r, busy_d;
  logic                 done_r, done_d;
  logic                 aborted_r, aborted_d;
  logic                 err_r, err_d;
  logic [3:0]           mask_r, mask_d;
  logic [1:0]           ch_r, ch_d;
  logic [ram_width-1:0] base_r, base_d;
  logic [ram_width-1:0] nsmp_r, nsmp_d;
  logic [ram_width-1:0] cnt_r, cnt_d;
  logic                 accept;
  logic                 boundary;
  logic [7:0]           q_sel;

  function automatic logic [1:0] first_chan(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  always_comb begin
    case (ch_r)
      2'd0:    q_sel = q1;
      2'd1:    q_sel = q2;
      2'd2:    q_sel = q3;
      default: q_sel = q4;
    endcase
  end

  assign accept = tx_valid_r & tx.tx_ready;

  always_comb begin
    state_d     = state_r;
    rden_d      = 1'b0;
    rdaddress_d = rdaddress_r;
    tx_data_d   = tx_data_r;
    tx_valid_d  = tx_valid_r;
    busy_d      = busy_r;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    err_d       = 1'b0;
    mask_d      = mask_r;
    ch_d        = ch_r;
    base_d      = base_r;
    nsmp_d      = nsmp_r;
    cnt_d       = cnt_r;
    boundary    = 1'b0;

    case (state_r)
      IDLE: begin
        if (start) begin
          if (data_ready) begin
            mask_d  = chan_mask;
            nsmp_d  = nsmp;
            base_d  = wraddress_triggerpoint - triggerpoint;
            busy_d  = 1'b1;
            ch_d    = first_chan(chan_mask);
            state_d = NEXTCH;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      NEXTCH: begin
        if (mask_r == 4'b0000) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          ch_d        = first_chan(mask_r);
          rdaddress_d = base_r;
          cnt_d       = '0;
          boundary    = 1'b1;
          if (HDR_EN) begin
            tx_data_d  = HDR_SYNC;
            tx_valid_d = 1'b1;
            state_d    = HDR0;
          end else if (nsmp_r == '0) begin
            // Empty channel without header: retire it and look at the next one.
            mask_d[first_chan(mask_r)] = 1'b0;
            state_d                    = NEXTCH;
          end else begin
            rden_d  = 1'b1;
            state_d = RDADDR;
          end
        end
      end

      HDR0: begin
        if (accept) begin
          tx_data_d = {6'b0, ch_r};
          state_d   = HDR1;
        end
      end

      HDR1: begin
        if (accept) begin
          tx_valid_d = 1'b0;
          boundary   = 1'b1;
          if (nsmp_r == '0) begin
            mask_d[ch_r] = 1'b0;
            state_d      = NEXTCH;
          end else begin
            rden_d  = 1'b1;
            state_d = RDADDR;
          end
        end
      end

      RDADDR: begin
        state_d = RDWAIT;
      end

      RDWAIT: begin
        tx_data_d  = q_sel;
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end

      SEND: begin
        if (accept) begin
          tx_valid_d  = 1'b0;
          rdaddress_d = rdaddress_r + ADDR_ONE;
          cnt_d       = cnt_r + ADDR_ONE;
          boundary    = 1'b1;
          if (cnt_r + ADDR_ONE == nsmp_r) begin
            mask_d[ch_r] = 1'b0;
            state_d      = NEXTCH;
          end else begin
            rden_d  = 1'b1;
            state_d = RDADDR;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Acquisition lost between bytes: stop without starting another RAM read.
    if (boundary && !data_ready) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      aborted_d  = 1'b1;
      rden_d     = 1'b0;
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      rden_r      <= 1'b0;
      rdaddress_r <= '0;
      tx_data_r   <= '0;
      tx_valid_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      aborted_r   <= 1'b0;
      err_r       <= 1'b0;
      mask_r      <= '0;
      ch_r        <= '0;
    end else begin
      state_r     <= state_d;
      rden_r      <= rden_d;
      rdaddress_r <= rdaddress_d;
      tx_data_r   <= tx_data_d;
      tx_valid_r  <= tx_valid_d;
      busy_r      <= busy_d;
      done_r      <= done_d;
      aborted_r   <= aborted_d;
      err_r       <= err_d;
      mask_r      <= mask_d;
      ch_r        <= ch_d;
    end
  end

  // Latched readout parameters and sample count; always written before use.
  always_ff @(posedge clk) begin
    base_r <= base_d;
    nsmp_r <= nsmp_d;
    cnt_r  <= cnt_d;
  end

  assign rden         = rden_r;
  assign rdaddress    = rdaddress_r;
  assign tx.tx_data   = tx_data_r;
  assign tx.tx_valid  = tx_valid_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign aborted      = aborted_r;
  assign err_notready = err_r;

endmodule

// File: tb/tb_sample_readout.sv
// Scoreboard bench for sample_readout: expected bytes and RAM addresses are queued
// when a readout is requested and popped as the DUT reads the RAM and streams bytes.
module tb_sample_readout;
  localparam int RW = 10;
`ifdef SAMPLE_READOUT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          data_ready;
  logic [3:0]    chan_mask;
  logic [RW-1:0] wraddress_triggerpoint;
  logic [RW-1:0] triggerpoint;
  logic [RW-1:0] nsmp;
  logic          rden;
  logic [RW-1:0] rdaddress;
  logic [7:0]    q1, q2, q3, q4;
  logic          busy, done, aborted, err_notready;

  sample_readout_if tx_if();

  sample_readout #(.ram_width(RW)) dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .start                  (start),
    .data_ready             (data_ready),
    .chan_mask              (chan_mask),
    .wraddress_triggerpoint (wraddress_triggerpoint),
    .triggerpoint           (triggerpoint),
    .nsmp                   (nsmp),
    .rden                   (rden),
    .rdaddress              (rdaddress),
    .q1                     (q1),
    .q2                     (q2),
    .q3                     (q3),
    .q4                     (q4),
    .tx                     (tx_if),
    .busy                   (busy),
    .done                   (done),
    .aborted                (aborted),
    .err_notready           (err_notready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0]    exp_byte[$];
  logic [RW-1:0] exp_addr[$];
  bit            hold_pending = 1'b0;
  logic [7:0]    held;

  function automatic logic [7:0] ram_val(input int c, input int a);
    int v;
    v = a * 37 + c * 101 + (a >> 3);
    return v[7:0] ^ 8'(c << 6);
  endfunction

  // Registered-read RAM model for the four channels.
  always @(posedge clk) begin
    if (rden) begin
      q1 <= ram_val(0, int'(rdaddress));
      q2 <= ram_val(1, int'(rdaddress));
      q3 <= ram_val(2, int'(rdaddress));
      q4 <= ram_val(3, int'(rdaddress));
    end
  end

  // Scoreboard monitor: RAM reads, accepted bytes, and valid/data hold under back-pressure.
  always @(negedge clk) begin
    logic [7:0]    eb;
    logic [RW-1:0] ea;
    if (!rstn) begin
      hold_pending = 1'b0;
    end else begin
      if (rden === 1'b1) begin
        checks++;
        if (exp_addr.size() == 0) begin
          failures++;
          $display("FAIL rd_addr unexpected read addr=%0d required=none", rdaddress);
        end else begin
          ea = exp_addr.pop_front();
          if (rdaddress !== ea) begin
            failures++;
            $display("FAIL rd_addr got=%0d required=%0d", rdaddress, ea);
          end
        end
      end
      if (hold_pending) begin
        checks++;
        if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== held) begin
          failures++;
          $display("FAIL tx_hold valid=%b data=%h required valid=1 data=%h",
                   tx_if.tx_valid, tx_if.tx_data, held);
        end
      end
      if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) begin
        checks++;
        if (exp_byte.size() == 0) begin
          failures++;
          $display("FAIL tx_byte unexpected byte=%h required=none", tx_if.tx_data);
        end else begin
          eb = exp_byte.pop_front();
          if (tx_if.tx_data !== eb) begin
            failures++;
            $display("FAIL tx_byte got=%h required=%h", tx_if.tx_data, eb);
          end
        end
      end
      hold_pending = (tx_if.tx_valid === 1'b1) && (tx_if.tx_ready !== 1'b1);
      held         = tx_if.tx_data;
    end
  end

  task automatic push_expect(input logic [3:0] m, input logic [RW-1:0] w,
                             input logic [RW-1:0] t, input logic [RW-1:0] n);
    logic [RW-1:0] b;
    logic [RW-1:0] a;
    b = w - t;
    for (int c = 0; c < 4; c++) begin
      if (m[c]) begin
        if (HDR != 0) begin
          exp_byte.push_back(8'hA5);
          exp_byte.push_back(8'(c));
        end
        for (int k = 0; k < int'(n); k++) begin
          a = b + RW'(k);
          exp_addr.push_back(a);
          exp_byte.push_back(ram_val(c, int'(a)));
        end
      end
    end
  endtask

  function automatic int exp_cycles(input logic [3:0] m, input int n);
    return 2 + $countones(m) * (1 + 2 * HDR + 3 * n);
  endfunction

  // Drives one readout and reports when done rose (cycle count from start), with no checking.
  task automatic run_readout(input logic [3:0] m, input logic [RW-1:0] w, input logic [RW-1:0] t,
                             input logic [RW-1:0] n, input bit rnd, input int restart_at,
                             output int cyc, output int ndone, output bit abt, output bit busy1);
    push_expect(m, w, t, n);
    chan_mask = m;
    wraddress_triggerpoint = w;
    triggerpoint = t;
    nsmp = n;
    tx_if.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chan_mask = 4'b1111;
    @(negedge clk);
    busy1 = busy;
    cyc = 1;
    ndone = 0;
    abt = 1'b0;
    while (cyc < 6000) begin
      if (done === 1'b1) begin
        ndone++;
        abt = aborted;
        break;
      end
      @(posedge clk); #1;
      if (rnd) tx_if.tx_ready = 1'($urandom_range(0, 1));
      start = (cyc + 1 == restart_at);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    tx_if.tx_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    start = 1'b0;
    data_ready = 1'b1;
    chan_mask = '0;
    wraddress_triggerpoint = '0;
    triggerpoint = '0;
    nsmp = '0;
    tx_if.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rden, rdaddress, tx_if.tx_valid, tx_if.tx_data} !== 20'd0) begin
      failures++;
      $display("FAIL reset_datapath got=%h required=0", {rden, rdaddress, tx_if.tx_valid, tx_if.tx_data});
    end
    checks++;
    if ({busy, done, aborted, err_notready} !== 4'd0) begin
      failures++;
      $display("FAIL reset_status got=%b required=0000", {busy, done, aborted, err_notready});
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_if.tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release busy=%b valid=%b required 0 0", busy, tx_if.tx_valid);
    end
  endtask

  task automatic test_readout(input string name, input logic [3:0] m, input logic [RW-1:0] w,
                              input logic [RW-1:0] t, input logic [RW-1:0] n, input bit rnd,
                              input int restart_at);
    int cyc, ndone;
    bit abt, busy1;
    run_readout(m, w, t, n, rnd, restart_at, cyc, ndone, abt, busy1);
    checks++;
    if (busy1 !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy_cycle1 got=%b required=1", name, busy1);
    end
    checks++;
    if (ndone != 1 || abt !== 1'b0) begin
      failures++;
      $display("FAIL %s_done done_pulses=%0d aborted=%b required 1 and 0", name, ndone, abt);
    end
    if (!rnd) begin
      checks++;
      if (cyc != exp_cycles(m, int'(n))) begin
        failures++;
        $display("FAIL %s_cycles got=%0d required=%0d", name, cyc, exp_cycles(m, int'(n)));
      end
    end
    checks++;
    if (exp_byte.size() != 0 || exp_addr.size() != 0) begin
      failures++;
      $display("FAIL %s_missing bytes_left=%0d reads_left=%0d required 0 0",
               name, exp_byte.size(), exp_addr.size());
    end
    exp_byte.delete();
    exp_addr.delete();
  endtask

  task automatic test_basic;
    test_readout("basic", 4'b0001, 10'd100, 10'd40, 10'd8, 1'b0, 0);
  endtask

  task automatic test_wrap;
    test_readout("wrap", 4'b0001, 10'd5, 10'd10, 10'd12, 1'b0, 0);
  endtask

  task automatic test_mask;
    test_readout("mask", 4'b1010, 10'd700, 10'd300, 10'd3, 1'b0, 0);
  endtask

  task automatic test_nsmp_zero;
    test_readout("nsmp0", 4'b1111, 10'd50, 10'd10, 10'd0, 1'b0, 0);
  endtask

  task automatic test_backpressure;
    test_readout("bp", 4'b1111, 10'd20, 10'd30, 10'd10, 1'b1, 0);
  endtask

  task automatic test_start_while_busy;
    test_readout("busy_start", 4'b0001, 10'd300, 10'd20, 10'd6, 1'b0, 5);
  endtask

  task automatic test_not_ready;
    data_ready = 1'b0;
    chan_mask = 4'b0001;
    nsmp = 10'd4;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (err_notready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL notready_pulse err=%b busy=%b required 1 0", err_notready, busy);
    end
    @(negedge clk);
    checks++;
    if (err_notready !== 1'b0 || busy !== 1'b0 || rden !== 1'b0) begin
      failures++;
      $display("FAIL notready_after err=%b busy=%b rden=%b required 0 0 0", err_notready, busy, rden);
    end
    data_ready = 1'b1;
  endtask

  task automatic test_abort;
    int k;
    bit seen;
    logic [RW-1:0] b;
    b = 10'd200 - 10'd50;
    if (HDR != 0) begin
      exp_byte.push_back(8'hA5);
      exp_byte.push_back(8'h00);
    end else begin
      exp_addr.push_back(b);
      exp_byte.push_back(ram_val(0, int'(b)));
    end
    chan_mask = 4'b0011;
    wraddress_triggerpoint = 10'd200;
    triggerpoint = 10'd50;
    nsmp = 10'd6;
    tx_if.tx_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    @(negedge clk);
    while (tx_if.tx_valid !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 50) begin
      failures++;
      $display("FAIL abort_first_valid timeout after %0d cycles required valid", k);
    end
    @(posedge clk); #1;
    data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tx_if.tx_ready = 1'b1;
    seen = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (aborted !== 1'b1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL abort_flags aborted=%b busy=%b required 1 0", aborted, busy);
        end
        break;
      end
      k++;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL abort_done timeout got=none required=done");
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || aborted !== 1'b0 || tx_if.tx_valid !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet done=%b aborted=%b valid=%b required 0 0 0",
                 done, aborted, tx_if.tx_valid);
      end
    end
    checks++;
    if (exp_byte.size() != 0 || exp_addr.size() != 0) begin
      failures++;
      $display("FAIL abort_missing bytes_left=%0d reads_left=%0d required 0 0",
               exp_byte.size(), exp_addr.size());
    end
    exp_byte.delete();
    exp_addr.delete();
    data_ready = 1'b1;
  endtask

  task automatic test_reset_mid;
    push_expect(4'b1111, 10'd512, 10'd100, 10'd20);
    chan_mask = 4'b1111;
    wraddress_triggerpoint = 10'd512;
    triggerpoint = 10'd100;
    nsmp = 10'd20;
    tx_if.tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    checks++;
    if ({rden, rdaddress, tx_if.tx_valid, tx_if.tx_data, busy, done, aborted, err_notready} !== 24'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h required=0",
               {rden, rdaddress, tx_if.tx_valid, tx_if.tx_data, busy, done, aborted, err_notready});
    end
    exp_byte.delete();
    exp_addr.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    test_readout("after_reset", 4'b0100, 10'd9, 10'd3, 10'd2, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_mask();
    test_nsmp_zero();
    test_backpressure();
    test_not_ready();
    test_start_while_busy();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_readout.md
# sample_readout

Readout engine for the four 8-bit channel sample RAMs that the acquisition block fills. On a readout request it walks the circular RAM from the pre-trigger start address, channel by channel, and streams bytes to the host-link transmitter over a valid/ready interface. It sits between the acquisition block (`data_ready`, `wraddress_triggerpoint`) and the byte transmitter, in the `clk` domain.

## Interface
Parameters:
- `ram_width`, 10, sample RAM address width; RAM depth is 2^ram_width.

Ports:
- `clk`  in  1  main FPGA clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle readout request.
- `data_ready`  in  1  acquisition complete, RAM contents valid.
- `chan_mask`  in  4  channels to send; bit i enables channel i+1.
- `wraddress_triggerpoint`  in  ram_width  write address at trigger.
- `triggerpoint`  in  ram_width  number of pre-trigger samples.
- `nsmp`  in  ram_width  samples per channel to send; 0 sends none.
- `rden`  out  1  RAM read enable.
- `rdaddress`  out  ram_width  RAM read address, shared by all four RAMs.
- `q1`, `q2`, `q3`, `q4`  in  8 each  RAM registered read data, valid the cycle after `rden`.
- `tx_data`  out  8  stream byte.
- `tx_valid`  out  1  byte valid.
- `tx_ready`  in  1  transmitter accepts.
- `busy`  out  1  readout in progress.
- `done`  out  1  one-cycle pulse at end of readout.
- `aborted`  out  1  one-cycle pulse, coincident with `done`, when the readout was cut short.
- `err_notready`  out  1  one-cycle pulse: `start` arrived while `data_ready` was 0.

## Operation
- Reset values: all outputs 0; `rdaddress` 0; state IDLE.
- States: IDLE, HDR0, HDR1, RDADDR, RDWAIT, SEND, NEXTCH.
- IDLE:
  - If `start` and `data_ready` are both 1: latch `chan_mask` and `nsmp`, and latch `base = wraddress_triggerpoint - triggerpoint` (mod 2^ram_width). Set `busy`, select the lowest enabled channel, go to NEXTCH.
  - If `start` is 1 and `data_ready` is 0: pulse `err_notready` and stay in IDLE.
  - `start` is ignored while `busy` is 1.
- NEXTCH:
  - If no enabled channel remains, pulse `done` and clear `busy` (IDLE).
  - Otherwise set `rdaddress` to `base` and clear the sample count.
  - Go to HDR0 when the header is compiled in, else RDADDR.
  - If the latched `nsmp` is 0, each channel emits only its header (or nothing when the header is not compiled in).
- RDADDR: assert `rden` for exactly one cycle at `rdaddress`, then RDWAIT.
- RDWAIT: load `tx_data` from the selected channel's `q` (`q1`..`q4`), then SEND.
- SEND:
  - Hold `tx_valid` and `tx_data` stable until `tx_valid & tx_ready`.
  - On acceptance: increment `rdaddress` (wraps modulo 2^ram_width, 2^ram_width-1 to 0) and increment the count.
  - If count reaches `nsmp`, clear this channel's mask bit and go to NEXTCH; else go to RDADDR.
- Abort: if `data_ready` is 0 at any byte boundary (entering RDADDR, HDR0 or NEXTCH) while `busy`, go to IDLE and pulse `done` and `aborted`. A byte already presented on `tx_valid` is always completed first; `tx_valid` never drops without acceptance.
- Channel order: ascending index (1, 2, 3, 4).

## Timing
- `start` at cycle 0 → `busy` = 1 at cycle 1.
- Without the header: first `rden` at cycle 2, first `tx_valid` at cycle 4.
- Per-byte cost with `tx_ready` held high: 3 cycles (RDADDR, RDWAIT, SEND). Every back-pressure cycle adds 1.
- `rden` and `rdaddress` are registered outputs.
- `done` is asserted in the cycle after the last acceptance plus one NEXTCH cycle. `busy` falls in the same cycle `done` is high.
- Total readout, no back-pressure, no header: 1 + Σ over channels (1 + 3·`nsmp`) + 1 cycles after `start`.

## Configuration
- `SAMPLE_READOUT_HEADER_EN`:
  - Defined: each channel's samples are preceded by two header bytes, sent in HDR0 then HDR1 with the same valid/ready hold rule: `8'hA5`, then `{6'b0, chan_idx[1:0]}` (0-based).
  - Not defined: HDR0 and HDR1 are never entered and the stream carries raw samples only.

## Test plan
- `wraddress_triggerpoint`=100, `triggerpoint`=40, `nsmp`=8, mask 4'b0001, `tx_ready`=1 → `rdaddress` 60..67, 8 bytes equal to RAM1[60..67], `done` once, `aborted` 0.
- Wrap: `wraddress_triggerpoint`=5, `triggerpoint`=10, `nsmp`=12 → addresses 1019..1023, 0..6.
- Mask 4'b1010, `nsmp`=3 → channel 2 bytes, then channel 4 bytes; with `SAMPLE_READOUT_HEADER_EN` defined: A5 01 s s s A5 03 s s s.
- `tx_ready` toggling randomly → `tx_data` stable while `tx_valid`=1 and not ready; no byte lost or duplicated.
- `start` with `data_ready`=0 → `err_notready` pulse, `busy` stays 0; `start` while busy → ignored.
- `data_ready` dropped mid-channel with `tx_ready`=0 → current byte completes on ready, then `done`+`aborted`, no further `rden`; `rstn` low mid-readout → all outputs 0 immediately.
